csa_accumulator: RTL

- Multi-cycle carry-save accumulator that sits directly upstream of the 11-bit carry-propagate adder stage.
- Takes a packet of WIDTH-bit operands over a valid/ready stream and reduces them with one 3:2 compressor row per beat. No carry propagation happens here.
- On the last beat it presents the redundant pair (sum vector, carry vector) for the downstream CPA to resolve.
- All arithmetic is modulo 2^WIDTH.

---
 rtl/csa_pkg.sv | 19 +
 rtl/csa_row.sv | 26 ++
 rtl/csa_accumulator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator: default widths,
// the FSM state encoding and the bitwise majority helper.
package csa_pkg;

  localparam int unsigned WIDTH_DEF = 11;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Single-bit majority; the full-adder carry.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational WIDTH-bit 3:2 compressor row. Each bit position is a full
// adder cell; the carry vector is shifted up one place and the carry out
// of the MSB is dropped, so s + carry == a + b + c (mod 2^WIDTH).
module csa_row
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] carry
);

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    // The MSB cell has no carry destination inside the vector width.
    if (i < WIDTH - 1) begin : g_cy
      assign carry[i+1] = maj3(a[i], b[i], c[i]);
    end
  end

endmodule

// File: rtl/csa_accumulator.sv
// Multi-cycle carry-save accumulator feeding the downstream CPA.
// Reduces one operand per accepted beat into a redundant (S, C) pair and
// presents it on the packet's last beat; no carry propagation here.
// Optional build macro: CSA_SHADOW_CHECK_EN adds a binary shadow sum and
// the out_mismatch self-check output.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_carry,
  output logic [CNT_W-1:0] out_count
`ifdef CSA_SHADOW_CHECK_EN
  ,
  output logic             out_mismatch
`endif
);

  state_t             state_q;
  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic [WIDTH-1:0]   row_s;
  logic [WIDTH-1:0]   row_c;
  logic [CNT_W-1:0]   cnt_d;
  logic               accept;

`ifdef CSA_SHADOW_CHECK_EN
  logic [WIDTH-1:0]   shadow_q;
  logic [WIDTH-1:0]   resolved;
`endif

  // in_ready is a register so it never follows in_valid combinationally.
  assign accept = in_valid & in_ready_q;

  csa_row #(.WIDTH(WIDTH)) u_row (
    .a     (s_q),
    .b     (c_q),
    .c     (in_data),
    .s     (row_s),
    .carry (row_c)
  );

  // Saturating beat counter next value.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Packet FSM: owns the S/C vectors, the count and the handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef CSA_SHADOW_CHECK_EN
      shadow_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            s_q   <= row_s;
            c_q   <= row_c;
            cnt_q <= cnt_d;
`ifdef CSA_SHADOW_CHECK_EN
            shadow_q <= shadow_q + in_data;
`endif
            if (in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef CSA_SHADOW_CHECK_EN
            shadow_q    <= '0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = s_q;
  assign out_carry = c_q;
  assign out_count = cnt_q;

`ifdef CSA_SHADOW_CHECK_EN
  // Resolve the redundant pair and compare against the binary shadow sum.
  always_comb begin
    resolved     = s_q + c_q;
    out_mismatch = (state_q == HOLD) && (resolved != shadow_q);
  end
`endif

endmodule
